// File: rtl/lane_arbiter_if.sv
// Request/control bundle between the interposer lane nodes and the lane arbiter.
// The arbiter sits on the slave side; the nodes (or a bench) drive the master side.
interface lane_arbiter_if #(
  parameter int NODE_COUNT         = 8,
  parameter int NODE_COUNT_DIGIT   = 3,
  parameter int ARBITER_SIGNAL_IN  = 3,
  parameter int ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1
);
  logic [NODE_COUNT*ARBITER_SIGNAL_OUT-1:0] request_in;
  logic [NODE_COUNT*ARBITER_SIGNAL_IN-1:0]  control_out;
  logic                                     busy;
  logic [NODE_COUNT_DIGIT-1:0]              grant_src;

  modport master (
    output request_in,
    input  control_out, busy, grant_src
  );

  modport slave (
    input  request_in,
    output control_out, busy, grant_src
  );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin central arbiter for one unidirectional interposer bus lane.
// `define LANE_ARB_SEGMENT_REUSE_EN allows several disjoint-span transfers per grant.
module lane_arbiter #(
  parameter int NODE_COUNT         = 8,
  parameter int NODE_COUNT_DIGIT   = 3,
  parameter int DIRECTION          = 0,
  parameter int ARBITER_SIGNAL_IN  = 3,
  parameter int ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1
) (
  input  logic          clk,
  input  logic          reset,
  lane_arbiter_if.slave bus
);
  localparam int NC = NODE_COUNT;
  localparam int ND = NODE_COUNT_DIGIT;
  localparam int SI = ARBITER_SIGNAL_IN;
  localparam int SO = ARBITER_SIGNAL_OUT;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e           state_q, state_d;
  logic [ND-1:0]    rr_q, rr_d;
  logic [ND-1:0]    src_q, src_d;
  logic [NC-1:0]    mask_q, mask_d;
  logic [NC*SI-1:0] ctrl_q, ctrl_d;

  logic [NC-1:0]    vld, legal, cand, sel;
  logic [ND-1:0]    dst [NC];
  logic             found;
  logic [ND-1:0]    first;

  always_comb begin
    for (int n = 0; n < NC; n++) begin
      vld[n]   = bus.request_in[n*SO+ND];
      dst[n]   = bus.request_in[n*SO +: ND];
      legal[n] = vld[n] && (int'(dst[n]) < NC) &&
                 ((DIRECTION == 0) ? (int'(dst[n]) > n)
                                   : (int'(dst[n]) < n));
      // last grant's sources sit out the turnaround cycle
      cand[n]  = legal[n] && !(state_q == GAP && mask_q[n]);
    end
  end

  always_comb begin : sel_p
`ifdef LANE_ARB_SEGMENT_REUSE_EN
    logic [NC-1:0] used;
    int            lo, hi;
    logic          clash;
`endif
    int            idx;
    logic [ND-1:0] ix;
    sel   = '0;
    found = 1'b0;
    first = '0;
`ifdef LANE_ARB_SEGMENT_REUSE_EN
    used  = '0;
`endif
    for (int i = 0; i < NC; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NC) idx = idx - NC;
      ix = ND'(idx);
`ifdef LANE_ARB_SEGMENT_REUSE_EN
      lo    = (DIRECTION == 0) ? idx : int'(dst[ix]);
      hi    = (DIRECTION == 0) ? int'(dst[ix]) : idx;
      clash = 1'b0;
      for (int j = 0; j < NC; j++)
        if (j >= lo && j <= hi && used[j]) clash = 1'b1;
      if (cand[ix] && !clash) begin
        sel[ix] = 1'b1;
        for (int j = 0; j < NC; j++)
          if (j >= lo && j <= hi) used[j] = 1'b1;
        if (!found) first = ix;
        found = 1'b1;
      end
`else
      if (cand[ix] && !found) begin
        sel[ix] = 1'b1;
        first   = ix;
        found   = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    mask_d  = mask_q;
    ctrl_d  = '0;
    for (int n = 0; n < NC; n++)
      ctrl_d[n*SI] = vld[n] && !legal[n];
    unique case (state_q)
      GRANT: state_d = GAP;
      default: begin
        if (found) begin
          state_d = GRANT;
          src_d   = first;
          mask_d  = sel;
          rr_d    = (int'(first) == NC - 1) ? '0 : first + 1'b1;
          for (int n = 0; n < NC; n++) begin
            if (sel[n]) begin
              ctrl_d[n*SI+2] = 1'b1;
              for (int m = 0; m < NC; m++)
                if (dst[n] == ND'(m)) ctrl_d[m*SI+1] = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      mask_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.control_out = ctrl_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_src   = src_q;
endmodule

// File: tb/tb_lane_arbiter.sv
// Bench for lane_arbiter: vector table, corner sequences and a random
// run of both lane directions against a queue-based reference model.
module tb_lane_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_arbiter_if #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3)) bus0 ();
  lane_arbiter_if #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3)) bus1 ();

  lane_arbiter #(.DIRECTION(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  lane_arbiter #(.DIRECTION(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [31:0] req;
    logic [23:0] ctrl;
    logic        busy;
    logic [2:0]  gsrc;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] rq(int s, int d);
    logic [31:0] r;
    r = '0;
    r[4*s +: 4] = {1'b1, 3'(d)};
    return r;
  endfunction

  function automatic logic [23:0] sd(int n);
    logic [23:0] c;
    c = '0;
    c[3*n+2] = 1'b1;
    return c;
  endfunction

  function automatic logic [23:0] rc(int n);
    logic [23:0] c;
    c = '0;
    c[3*n+1] = 1'b1;
    return c;
  endfunction

  function automatic logic [23:0] nk(int n);
    logic [23:0] c;
    c = '0;
    c[3*n] = 1'b1;
    return c;
  endfunction

  task automatic add(input logic r, input logic [31:0] q,
                     input logic [23:0] c, input logic b, input int g);
    vec_t v;
    v.rst = r; v.req = q; v.ctrl = c; v.busy = b; v.gsrc = 3'(g);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: phase 0=idle 1=grant 2=gap
  int          m_phase [2];
  int          m_rr    [2];
  bit [7:0]    m_mask  [2];
  logic [23:0] e_ctrl  [2];
  logic        e_busy  [2];
  int          e_gsrc  [2];

  task automatic model_step(input int dir, input logic rst,
                            input logic [31:0] req);
    int order[$];
    int acc[$];
    int dv[8];
    bit vv[8];
    bit lg[8];
    bit ok;
    int s;
    logic [23:0] c;
    if (rst) begin
      m_phase[dir] = 0; m_rr[dir] = 0; m_mask[dir] = '0;
      e_ctrl[dir] = '0; e_busy[dir] = 1'b0; e_gsrc[dir] = 0;
      return;
    end
    c = '0;
    for (int n = 0; n < 8; n++) begin
      vv[n] = req[4*n+3];
      dv[n] = int'(req[4*n +: 3]);
      lg[n] = vv[n] && ((dir == 0) ? (dv[n] > n) : (dv[n] < n));
      if (vv[n] && !lg[n]) c[3*n] = 1'b1;
    end
    if (m_phase[dir] == 1) begin
      m_phase[dir] = 2;
    end else begin
      for (int k = 0; k < 8; k++) begin
        s = (m_rr[dir] + k) % 8;
        if (lg[s] && !(m_phase[dir] == 2 && m_mask[dir][s]))
          order.push_back(s);
      end
      if (order.size() == 0) begin
        m_phase[dir] = 0;
      end else begin
        foreach (order[k]) begin
          s = order[k];
          ok = (k == 0);
`ifdef LANE_ARB_SEGMENT_REUSE_EN
          ok = 1'b1;
          foreach (acc[a])
            if ((s < dv[s] ? s : dv[s]) <= (acc[a] > dv[acc[a]] ? acc[a] : dv[acc[a]]) &&
                (acc[a] < dv[acc[a]] ? acc[a] : dv[acc[a]]) <= (s > dv[s] ? s : dv[s]))
              ok = 1'b0;
`endif
          if (ok) acc.push_back(s);
        end
        m_mask[dir] = '0;
        foreach (acc[a]) begin
          c[3*acc[a]+2] = 1'b1;
          c[3*dv[acc[a]]+1] = 1'b1;
          m_mask[dir][acc[a]] = 1'b1;
        end
        e_gsrc[dir] = order[0];
        m_rr[dir] = (order[0] + 1) % 8;
        m_phase[dir] = 1;
      end
    end
    e_ctrl[dir] = c;
    e_busy[dir] = (m_phase[dir] != 0);
  endtask

  function automatic logic [31:0] rand_req(input logic [31:0] prev);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 8; n++)
      if ($urandom_range(0, 2) == 0)
        r[4*n +: 4] = {1'b1, 3'($urandom_range(0, 7))};
    return ($urandom_range(0, 1) == 1) ? prev : r;
  endfunction

  initial begin
    logic [31:0] R, N, r0, r1;
    logic        rs;
    R = rq(1, 7) | rq(3, 7) | rq(6, 7);
    N = rq(4, 2) | rq(5, 5);

    add(0, rq(2, 5), sd(2) | rc(5), 1, 2);
    add(0, rq(2, 5), '0, 1, 2);
    add(0, '0, '0, 0, 2);
    add(1, '0, '0, 0, 0);
    add(0, R, sd(1) | rc(7), 1, 1);
    add(0, R, '0, 1, 1);
    add(0, R, sd(3) | rc(7), 1, 3);
    add(0, R, '0, 1, 3);
    add(0, R, sd(6) | rc(7), 1, 6);
    add(0, R, '0, 1, 6);
    add(0, R, sd(1) | rc(7), 1, 1);
    add(0, '0, '0, 1, 1);
    add(0, '0, '0, 0, 1);
    add(0, N, nk(4) | nk(5), 0, 1);
    add(0, N, nk(4) | nk(5), 0, 1);
    add(0, N | rq(2, 3) | rq(3, 4), sd(2) | rc(3) | nk(4) | nk(5), 1, 2);
    add(0, N | rq(3, 4), nk(4) | nk(5), 1, 2);
    add(0, rq(3, 4), sd(3) | rc(4), 1, 3);
    add(0, '0, '0, 1, 3);
    add(0, '0, '0, 0, 3);
    add(0, rq(0, 3), sd(0) | rc(3), 1, 0);
    add(1, rq(0, 3), '0, 0, 0);
    add(0, rq(0, 3) | rq(1, 3), sd(0) | rc(3), 1, 0);
    add(0, '0, '0, 1, 0);
    add(0, '0, '0, 0, 0);
    add(0, rq(2, 5), sd(2) | rc(5), 1, 2);
    add(0, rq(2, 5), '0, 1, 2);
    add(0, rq(2, 5), '0, 0, 2);
    add(0, rq(2, 5), sd(2) | rc(5), 1, 2);
    add(0, '0, '0, 1, 2);
    add(0, '0, '0, 0, 2);

    reset = 1'b1;
    bus0.request_in = '0;
    bus1.request_in = '0;
    step();
    chk("reset ctrl", 32'(bus0.control_out), '0);
    chk("reset busy", 32'(bus0.busy), '0);
    chk("reset gsrc", 32'(bus0.grant_src), '0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      bus0.request_in = tbl[i].req;
      step();
      chk($sformatf("vec%0d ctrl", i), 32'(bus0.control_out), 32'(tbl[i].ctrl));
      chk($sformatf("vec%0d busy", i), 32'(bus0.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d gsrc", i), 32'(bus0.grant_src), 32'(tbl[i].gsrc));
    end
    reset = 1'b0;
    bus0.request_in = '0;

    // high-to-low lane: node 7 held through GAP, then rr wrap
    reset = 1'b1; step(); reset = 1'b0;
    bus1.request_in = rq(7, 0);
    step();
    chk("d1 g7 ctrl", 32'(bus1.control_out), 32'(sd(7) | rc(0)));
    chk("d1 g7 gsrc", 32'(bus1.grant_src), 7);
    step();
    chk("d1 gap ctrl", 32'(bus1.control_out), '0);
    chk("d1 gap busy", 32'(bus1.busy), 1);
    step();
    chk("d1 masked busy", 32'(bus1.busy), 0);
    chk("d1 masked ctrl", 32'(bus1.control_out), '0);
    bus1.request_in = rq(7, 0) | rq(5, 1);
    step();
    chk("d1 wrap ctrl", 32'(bus1.control_out), 32'(sd(5) | rc(1)));
    chk("d1 wrap gsrc", 32'(bus1.grant_src), 5);
    bus1.request_in = '0;
    step(); step();
    chk("d1 idle busy", 32'(bus1.busy), 0);

`ifdef LANE_ARB_SEGMENT_REUSE_EN
    reset = 1'b1; step(); reset = 1'b0;
    bus0.request_in = rq(0, 2) | rq(4, 6);
    step();
    chk("reuse dual ctrl", 32'(bus0.control_out),
        32'(sd(0) | rc(2) | sd(4) | rc(6)));
    chk("reuse dual gsrc", 32'(bus0.grant_src), 0);
    reset = 1'b1; step(); reset = 1'b0;
    bus0.request_in = rq(0, 4) | rq(2, 6);
    step();
    chk("reuse olap ctrl", 32'(bus0.control_out), 32'(sd(0) | rc(4)));
    step();
    chk("reuse olap gap", 32'(bus0.control_out), '0);
    bus0.request_in = rq(2, 6);
    step();
    chk("reuse olap next", 32'(bus0.control_out), 32'(sd(2) | rc(6)));
    chk("reuse olap gsrc", 32'(bus0.grant_src), 2);
    bus0.request_in = '0;
    step(); step();
`endif

    reset = 1'b1;
    model_step(0, 1'b1, '0);
    model_step(1, 1'b1, '0);
    step();
    r0 = '0;
    r1 = '0;
    for (int t = 0; t < 3000; t++) begin
      r0 = rand_req(r0);
      r1 = rand_req(r1);
      rs = ($urandom_range(0, 99) == 0);
      reset = rs;
      bus0.request_in = r0;
      bus1.request_in = r1;
      model_step(0, rs, r0);
      model_step(1, rs, r1);
      step();
      chk("rand0 ctrl", 32'(bus0.control_out), 32'(e_ctrl[0]));
      chk("rand0 busy", 32'(bus0.busy), 32'(e_busy[0]));
      chk("rand0 gsrc", 32'(bus0.grant_src), 32'(e_gsrc[0]));
      chk("rand1 ctrl", 32'(bus1.control_out), 32'(e_ctrl[1]));
      chk("rand1 busy", 32'(bus1.busy), 32'(e_busy[1]));
      chk("rand1 gsrc", 32'(bus1.grant_src), 32'(e_gsrc[1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_arbiter.md
Name: lane_arbiter

Overview:
Central arbiter for one unidirectional lane of the multipoint interposer bus. It is the responder to the per-node request/control handshake. It samples the request word from every node, selects one legal transfer by round-robin, and drives the registered 3-bit control word back to each node. Two instances exist per system: DIRECTION=0 (low-to-high lane) and DIRECTION=1 (high-to-low lane).

Parameters:
NODE_COUNT, 8, number of attached nodes
NODE_COUNT_DIGIT, 3, bits of a node address
DIRECTION, 0, 0 = only dest > src legal; 1 = only dest < src legal
ARBITER_SIGNAL_IN, 3, control word width per node (node-side input)
ARBITER_SIGNAL_OUT, NODE_COUNT_DIGIT+1, request word width per node (node-side output)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
request_in  input  NODE_COUNT*ARBITER_SIGNAL_OUT  request from node n at slice n.
  - Slice layout: {valid, dest[NODE_COUNT_DIGIT-1:0]}.
control_out  output  NODE_COUNT*ARBITER_SIGNAL_IN  control to node n at slice n.
  - Slice layout: {send, receive, nack}.
busy  output  1  high while the state is GRANT or GAP
grant_src  output  NODE_COUNT_DIGIT  source of the most recent grant, held until the next grant

Behaviour:
- Reset (sampled at posedge while reset=1): control_out=0, busy=0, grant_src=0, rr_ptr=0, state=IDLE. This takes effect on the next edge regardless of the current state, so an in-flight GRANT is dropped and no receive pulse escapes.
- States:
  - IDLE: evaluate requests every cycle.
  - GRANT: exactly 1 cycle with send/receive asserted.
  - GAP: exactly 1 cycle, all send/receive=0 (bus turnaround).
  - After GAP, the arbiter evaluates requests that same cycle, exactly as in IDLE.
- Legality of request n: valid=1, dest != n, dest < NODE_COUNT, and dest>n (DIRECTION=0) or dest<n (DIRECTION=1).
- Illegal valid request:
  - nack for node n is asserted for 1 cycle on the next edge.
  - nack is asserted in whichever state the arbiter is in.
  - The request is never granted and does not move rr_ptr.
  - nack re-pulses every cycle while the illegal request stays asserted.
- Evaluation (IDLE, or the cycle after GAP):
  - Winner = first legal requester at or after rr_ptr, scanning upward modulo NODE_COUNT.
  - On the next edge: state=GRANT, send[winner]=1, receive[dest]=1, grant_src=winner, rr_ptr=(winner+1) mod NODE_COUNT.
  - With no legal requester, stay in IDLE with control_out=0 except nack.
- Latency: request valid at edge k produces control at edge k+1 (1-cycle registered) when idle.
- GRANT -> GAP unconditionally. GAP -> GRANT if a legal requester exists, else GAP -> IDLE.
- Request masking: the node just granted is masked during GAP. A node deasserts its request the cycle after it sees send; masking prevents a stale request from being double-granted. The next grant to the same node is at least 2 cycles after GAP.
- Simultaneous requests to the same dest: only the round-robin winner is granted; the others stay pending.
- rr_ptr wrap: winner NODE_COUNT-1 sets rr_ptr=0.
- All outputs are registered; there is no combinational request-to-control path.

Optional Feature:
LANE_ARB_SEGMENT_REUSE_EN
- Defined:
  - A single GRANT may carry multiple transfers whose address spans are disjoint.
  - Span = [min(src,dest), max(src,dest)]; spans that only share an endpoint node also conflict.
  - Candidates are chosen greedily in round-robin order: each legal requester is accepted if its span overlaps no already-accepted span.
  - rr_ptr advances past the first (round-robin-priority) winner only.
  - grant_src reports that first winner.
  - All accepted sources are masked during GAP.
- Undefined: exactly one transfer per GRANT, as described above.

Test Plan:
- Reset, then node 2 requests dest 5 (DIRECTION=0) at cycle 0 -> cycle 1: send[2]=1, receive[5]=1, grant_src=2, busy=1. Cycle 2: GAP, control 0. Cycle 3: IDLE, busy=0.
- Nodes 1, 3, 6 request continuously to dest 7, rr_ptr=0 -> grants in order 1, 3, 6, 1 on cycles 1, 3, 5, 7.
- DIRECTION=0, node 4 requests dest 2; node 5 requests dest 5 -> nack[4]=1 and nack[5]=1 each cycle, never send, rr_ptr unchanged.
- Reset asserted during the GRANT cycle of node 0->3 -> next edge control_out=0, busy=0, rr_ptr=0. A later request from node 0 is granted normally.
- Node 7 granted (DIRECTION=1, dest 0) -> rr_ptr=0. Node 7 holds its request through GAP -> not re-granted until after GAP.
- With LANE_ARB_SEGMENT_REUSE_EN: requests 0->2 and 4->6 -> both send[0] and send[4] in the same GRANT cycle. Requests 0->4 and 2->6 -> only 0->4 is granted; 2->6 follows after GAP.
